// File: rtl/clock_divider_bank.sv
// Bank of independent programmable dividers producing a one-cycle tick and a 50%-duty
// square wave per channel; divisor changes are staged and applied only at terminal count.

module clock_divider_channel_checker (
    input logic clk,
    input logic reset,
    input logic tick,
    input logic clk_out,
    input logic cnt_zero
);

    // A tick is only produced by a terminal count, which always leaves the counter at zero.
    a_tick_cnt_zero: assert property (@(posedge clk) tick |-> cnt_zero);

    // Outside reset, the square wave can only move together with a tick.
    a_clk_edge_has_tick: assert property (@(posedge clk)
        (!reset && !$past(reset) && (clk_out != $past(clk_out))) |-> tick);

endmodule

module clock_divider_channel #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_div,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO      = WIDTH'(0);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] d_act_r;
    logic [WIDTH-1:0] d_stg_r;
    logic             pend_r;
    logic             tick_r;
    logic             clk_out_r;
    logic [WIDTH-1:0] d_eff_s;
    logic             tc_s;

    // Effective divisor and terminal count; >= lets an oversized count wrap after a shrink.
    always_comb begin
        d_eff_s = ONE;
        tc_s    = 1'b0;
        if (d_act_r == ZERO) begin
            d_eff_s = ONE;
        end else begin
            d_eff_s = d_act_r;
        end
        if (en) begin
            tc_s = (cnt_r >= (d_eff_s - ONE));
        end else begin
            tc_s = 1'b0;
        end
    end

    // Counter, divisor staging/apply and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= ZERO;
            d_act_r   <= RESET_DIV;
            d_stg_r   <= RESET_DIV;
            pend_r    <= 1'b0;
            tick_r    <= 1'b0;
            clk_out_r <= 1'b0;
        end else begin
            if (en) begin
                if (tc_s) begin
                    cnt_r     <= ZERO;
                    clk_out_r <= ~clk_out_r;
                    tick_r    <= 1'b1;
                    if (pend_r) begin
                        d_act_r <= d_stg_r;
                        pend_r  <= 1'b0;
                    end
                end else begin
                    cnt_r  <= cnt_r + ONE;
                    tick_r <= 1'b0;
                end
            end else begin
                tick_r <= 1'b0;
                // An idle channel has no period to protect, so apply at once and restart.
                if (pend_r) begin
                    d_act_r <= d_stg_r;
                    pend_r  <= 1'b0;
                    cnt_r   <= ZERO;
                end
            end
            // A write lands after any apply above, so a same-cycle write stays staged.
            if (wr_sel) begin
                d_stg_r <= wr_div;
                pend_r  <= 1'b1;
            end
        end
    end

    assign pending = pend_r;
    assign tick    = tick_r;
    assign clk_out = clk_out_r;

    clock_divider_channel_checker u_chk (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_r),
        .clk_out  (clk_out_r),
        .cnt_zero (cnt_r == ZERO)
    );

endmodule

module clock_divider_bank #(
    parameter  int NUM_CH      = 4,
    parameter  int WIDTH       = 32,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    logic [NUM_CH-1:0] wr_sel_s;

    // Write decode; channel numbers beyond the bank match no slot and are dropped.
    always_comb begin
        wr_sel_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en[g]),
            .wr_sel  (wr_sel_s[g]),
            .wr_div  (wr_div),
            .pending (pending[g]),
            .tick    (tick[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: a power-up vector table, a cycle scoreboard
// fed by a behavioural model, and hand-written sequences for the divisor-change corners.

module tb_clock_divider_bank;

    localparam int NUM_CH      = 5;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;
    localparam int CH_W        = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WIDTH-1:0]  wr_div;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_bank #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .pending (pending),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] clk_out;
        logic [NUM_CH-1:0] pending;
    } exp_t;

    typedef struct {
        logic              rst;
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] clk_out;
        logic [NUM_CH-1:0] pending;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    logic [WIDTH-1:0] m_cnt  [NUM_CH];
    logic [WIDTH-1:0] m_dact [NUM_CH];
    logic [WIDTH-1:0] m_dstg [NUM_CH];
    logic             m_pend [NUM_CH];
    logic             m_clk  [NUM_CH];
    logic             m_tick [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model of one clock edge, using the inputs currently driven.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            logic [WIDTH-1:0] d_eff;
            logic [WIDTH-1:0] n_cnt;
            logic [WIDTH-1:0] n_dact;
            logic [WIDTH-1:0] n_dstg;
            logic             n_pend;
            logic             n_clk;
            logic             n_tick;
            if (reset) begin
                n_cnt  = WIDTH'(0);
                n_dact = WIDTH'(DEFAULT_DIV);
                n_dstg = WIDTH'(DEFAULT_DIV);
                n_pend = 1'b0;
                n_clk  = 1'b0;
                n_tick = 1'b0;
            end else begin
                d_eff  = (m_dact[c] == WIDTH'(0)) ? WIDTH'(1) : m_dact[c];
                n_cnt  = m_cnt[c];
                n_dact = m_dact[c];
                n_dstg = m_dstg[c];
                n_pend = m_pend[c];
                n_clk  = m_clk[c];
                n_tick = 1'b0;
                if (en[c]) begin
                    if (m_cnt[c] >= d_eff - WIDTH'(1)) begin
                        n_cnt  = WIDTH'(0);
                        n_clk  = ~m_clk[c];
                        n_tick = 1'b1;
                        if (m_pend[c]) begin
                            n_dact = m_dstg[c];
                            n_pend = 1'b0;
                        end
                    end else begin
                        n_cnt = m_cnt[c] + WIDTH'(1);
                    end
                end else if (m_pend[c]) begin
                    n_dact = m_dstg[c];
                    n_pend = 1'b0;
                    n_cnt  = WIDTH'(0);
                end
                if (wr_en && (int'(wr_ch) == c)) begin
                    n_dstg = wr_div;
                    n_pend = 1'b1;
                end
            end
            m_cnt[c]  = n_cnt;
            m_dact[c] = n_dact;
            m_dstg[c] = n_dstg;
            m_pend[c] = n_pend;
            m_clk[c]  = n_clk;
            m_tick[c] = n_tick;
        end
    endtask

    // One clock: predict, queue the expectation, take the edge, compare.
    task automatic step();
        exp_t e;
        model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            e.tick[c]    = m_tick[c];
            e.clk_out[c] = m_clk[c];
            e.pending[c] = m_pend[c];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_tick", 32'(tick), 32'(e.tick));
            check("sb_clk_out", 32'(clk_out), 32'(e.clk_out));
            check("sb_pending", 32'(pending), 32'(e.pending));
        end
    endtask

    task automatic wait_tick(input int ch, output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            n++;
            if (tick[ch] === 1'b1) found = 1'b1;
        end
    endtask

    task automatic gap_check(input int ch, input int expected, input string name);
        int n;
        wait_tick(ch, n);
        check(name, 32'(n), 32'(expected));
    endtask

    task automatic write(input int ch, input int val);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_div = WIDTH'(val);
        step();
        wr_en  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Power-up with DEFAULT_DIV=4: tick every 4th edge, clk_out rises with the first tick.
        vecs[0] = '{1'b1, 5'h1f, 5'h00, 5'h00, 5'h00};
        vecs[1] = '{1'b1, 5'h1f, 5'h00, 5'h00, 5'h00};
        vecs[2] = '{1'b0, 5'h1f, 5'h00, 5'h00, 5'h00};
        vecs[3] = '{1'b0, 5'h1f, 5'h00, 5'h00, 5'h00};
        vecs[4] = '{1'b0, 5'h1f, 5'h00, 5'h00, 5'h00};
        vecs[5] = '{1'b0, 5'h1f, 5'h1f, 5'h1f, 5'h00};
        vecs[6] = '{1'b0, 5'h1f, 5'h00, 5'h1f, 5'h00};
        vecs[7] = '{1'b0, 5'h1f, 5'h00, 5'h1f, 5'h00};
        vecs[8] = '{1'b0, 5'h1f, 5'h00, 5'h1f, 5'h00};
        vecs[9] = '{1'b0, 5'h1f, 5'h1f, 5'h00, 5'h00};

        reset  = 1'b1;
        en     = 5'h1f;
        wr_en  = 1'b0;
        wr_ch  = 3'd0;
        wr_div = 8'd0;

        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst;
            en    = vecs[i].en;
            step();
            check("t1_tick", 32'(tick), 32'(vecs[i].tick));
            check("t1_clk_out", 32'(clk_out), 32'(vecs[i].clk_out));
            check("t1_pending", 32'(pending), 32'(vecs[i].pending));
        end

        // Divide by 1 and by 0 (stored 0 runs as 1).
        write(0, 1);
        write(1, 0);
        repeat (8) step();
        check("t2_pending", 32'(pending[1:0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            gap_check(0, 1, "t2_div1_gap");
            gap_check(1, 1, "t2_div0_gap");
        end

        // Glitch-free change on ch2: D=10, write 3 at cnt=4.
        en[2] = 1'b0;
        write(2, 10);
        step();
        check("t3_idle_apply", 32'(pending[2]), 32'd0);
        en[2] = 1'b1;
        repeat (4) step();
        write(2, 3);
        check("t3_pending_set", 32'(pending[2]), 32'd1);
        gap_check(2, 5, "t3_old_period_done");
        check("t3_pending_clear", 32'(pending[2]), 32'd0);
        gap_check(2, 3, "t3_new_gap_a");
        gap_check(2, 3, "t3_new_gap_b");

        // Pause ch3 (D=8) at cnt=2 for 5 cycles.
        en[3] = 1'b0;
        write(3, 8);
        step();
        en[3] = 1'b1;
        step();
        step();
        en[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_tick_paused", 32'(tick[3]), 32'd0);
        end
        en[3] = 1'b1;
        gap_check(3, 6, "t4_resume_gap");
        gap_check(3, 8, "t4_full_gap");

        // Edge writes on ch4.
        write(5, 5);
        write(7, 5);
        check("t5_bad_channel", 32'(pending), 32'd0);
        wait_tick(4, n);
        repeat (3) step();
        write(4, 5);
        check("t5_tc_write_tick", 32'(tick[4]), 32'd1);
        check("t5_tc_write_pend", 32'(pending[4]), 32'd1);
        gap_check(4, 4, "t5_old_period_kept");
        check("t5_applied", 32'(pending[4]), 32'd0);
        gap_check(4, 5, "t5_new_gap");
        write(4, 7);
        write(4, 9);
        gap_check(4, 3, "t5_pending_tc");
        check("t5_last_applied", 32'(pending[4]), 32'd0);
        gap_check(4, 9, "t5_last_write_wins");

        // Reset mid-operation with a simultaneous write.
        wait_tick(3, n);
        repeat (5) step();
        write(3, 2);
        check("t6_pending_before", 32'(pending[3]), 32'd1);
        reset  = 1'b1;
        wr_en  = 1'b1;
        wr_ch  = 3'd3;
        wr_div = 8'd2;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        check("t6_tick_reset", 32'(tick), 32'd0);
        check("t6_clk_reset", 32'(clk_out), 32'd0);
        check("t6_pend_reset", 32'(pending), 32'd0);
        gap_check(3, 4, "t6_write_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
